// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on operands and results.
// Single-cycle logic/arith/shift ops, plus an unsigned shift-add multiply that takes WIDTH cycles.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             inValid,
   output logic             inReady,
   output logic [WIDTH-1:0] dataOut,
   output logic [WIDTH-1:0] hiOut,
   output logic             illegal,
   output logic             outValid,
   input  logic             outReady
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int CNT_W = SHW + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   localparam logic [5:0] OP_AND   = 6'b100100;
   localparam logic [5:0] OP_OR    = 6'b100101;
   localparam logic [5:0] OP_ADD   = 6'b100000;
   localparam logic [5:0] OP_SUB   = 6'b100010;
   localparam logic [5:0] OP_SLT   = 6'b101010;
   localparam logic [5:0] OP_SLL   = 6'b000000;
   localparam logic [5:0] OP_SRL   = 6'b000010;
   localparam logic [5:0] OP_MULTU = 6'b011001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic                 ill_q, ill_d;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH-1:0]     mul_addend;

   // Returns {illegal, result} for every single-cycle function code.
   function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [5:0]       sig);
      logic [WIDTH-1:0] diff;
      logic             ovf;
      logic [WIDTH:0]   r;
      diff = a - b;
      // Signed overflow: operands differ in sign and the result sign differs from A.
      ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]);
      r    = '0;
      case (sig)
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_ADD:  r = {1'b0, a + b};
         OP_SUB:  r = {1'b0, diff};
         OP_SLT:  r = {1'b0, {(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf};
         OP_SLL:  r = {1'b0, a << b[SHW-1:0]};
         OP_SRL:  r = {1'b0, a >> b[SHW-1:0]};
         default: r = {1'b1, {WIDTH{1'b0}}};
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         ill_q    <= ill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      prod_d     = prod_q;
      cnt_d      = cnt_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      ill_d      = ill_q;
      mul_addend = mplier_q[0] ? mcand_q : '0;
      mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

      case (state_q)
         S_IDLE: begin
            if (inValid) begin
               if (Signal == OP_MULTU) begin
                  mcand_d  = dataA;
                  mplier_d = dataB;
                  prod_d   = '0;
                  cnt_d    = CNT_INIT;
                  state_d  = S_MUL;
               end else begin
                  {ill_d, lo_d} = alu_eval(dataA, dataB, Signal);
                  hi_d          = '0;
                  state_d       = S_DONE;
               end
            end
         end
         S_MUL: begin
            // Carry-out of the upper-half add is shifted back in as the new MSB.
            prod_d   = {mul_sum, prod_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
               lo_d    = prod_d[WIDTH-1:0];
               hi_d    = prod_d[2*WIDTH-1:WIDTH];
               ill_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (outReady) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign inReady  = (state_q == S_IDLE);
   assign outValid = (state_q == S_DONE);
   assign dataOut  = lo_q;
   assign hiOut    = hi_q;
   assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc with hand-computed expected results.
module tb_alu_mc;

   localparam int W = 32;

   localparam logic [5:0] OP_AND   = 6'b100100;
   localparam logic [5:0] OP_OR    = 6'b100101;
   localparam logic [5:0] OP_ADD   = 6'b100000;
   localparam logic [5:0] OP_SUB   = 6'b100010;
   localparam logic [5:0] OP_SLT   = 6'b101010;
   localparam logic [5:0] OP_SLL   = 6'b000000;
   localparam logic [5:0] OP_SRL   = 6'b000010;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] dataA, dataB;
   logic [5:0]   Signal;
   logic         inValid, inReady;
   logic [W-1:0] dataOut, hiOut;
   logic         illegal, outValid, outReady;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .dataA    (dataA),
      .dataB    (dataB),
      .Signal   (Signal),
      .inValid  (inValid),
      .inReady  (inReady),
      .dataOut  (dataOut),
      .hiOut    (hiOut),
      .illegal  (illegal),
      .outValid (outValid),
      .outReady (outReady)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called 1 time unit after a rising edge with the DUT in IDLE.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] sig);
      dataA   = a;
      dataB   = b;
      Signal  = sig;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      dataA   = ~a;
      dataB   = ~b;
      Signal  = 6'b010101;
   endtask

   task automatic wait_done(output int lat, output int rdy_seen);
      lat      = 1;
      rdy_seen = 0;
      while (!outValid && lat < 200) begin
         if (inReady) rdy_seen++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume(input string tag);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      check({tag, "/outValid_after"}, {63'd0, outValid}, 64'd0);
      check({tag, "/inReady_after"}, {63'd0, inReady}, 64'd1);
   endtask

   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [5:0] sig, input logic [W-1:0] exp_lo,
                      input logic [W-1:0] exp_hi, input logic exp_ill, input int exp_lat);
      int lat, rdy;
      start_op(a, b, sig);
      wait_done(lat, rdy);
      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/inReady_busy"}, 64'(rdy), 64'd0);
      check({tag, "/dataOut"}, {32'd0, dataOut}, {32'd0, exp_lo});
      check({tag, "/hiOut"}, {32'd0, hiOut}, {32'd0, exp_hi});
      check({tag, "/illegal"}, {63'd0, illegal}, {63'd0, exp_ill});
      consume(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rdy;
      reset_n  = 1'b0;
      dataA    = '0;
      dataB    = '0;
      Signal   = '0;
      inValid  = 1'b0;
      outReady = 1'b0;
      #12;
      check("rst/inReady", {63'd0, inReady}, 64'd1);
      check("rst/outValid", {63'd0, outValid}, 64'd0);
      check("rst/dataOut", {32'd0, dataOut}, 64'd0);
      check("rst/hiOut", {32'd0, hiOut}, 64'd0);
      check("rst/illegal", {63'd0, illegal}, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      run("add_wrap",  32'hFFFFFFFF, 32'h00000001, OP_ADD,   32'h00000000, 32'h0, 1'b0, 1);
      run("slt_ovf",   32'h80000000, 32'h00000001, OP_SLT,   32'h00000001, 32'h0, 1'b0, 1);
      run("slt_ovf2",  32'h7FFFFFFF, 32'hFFFFFFFF, OP_SLT,   32'h00000000, 32'h0, 1'b0, 1);
      run("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULTU, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33);

      // Abort a multiply with reset; the previous product is non-zero so the clear is visible.
      start_op(32'h12345678, 32'h9ABCDEF0, OP_MULTU);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b0;
      #1;
      check("abort/outValid", {63'd0, outValid}, 64'd0);
      check("abort/dataOut", {32'd0, dataOut}, 64'd0);
      check("abort/hiOut", {32'd0, hiOut}, 64'd0);
      check("abort/inReady", {63'd0, inReady}, 64'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort/inReady_rel", {63'd0, inReady}, 64'd1);
      check("abort/outValid_rel", {63'd0, outValid}, 64'd0);
      run("add_3_4",   32'd3, 32'd4, OP_ADD, 32'd7, 32'h0, 1'b0, 1);

      // Backpressure: result held while outReady is low; new requests ignored.
      start_op(32'hF0F0F0F0, 32'hFF00FF00, OP_AND);
      wait_done(lat, rdy);
      check("bp/latency", 64'(lat), 64'd1);
      inValid = 1'b1;
      dataA   = 32'd1;
      dataB   = 32'd1;
      Signal  = OP_ADD;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp/dataOut", {32'd0, dataOut}, {32'd0, 32'hF000F000});
         check("bp/outValid", {63'd0, outValid}, 64'd1);
         check("bp/inReady", {63'd0, inReady}, 64'd0);
      end
      inValid = 1'b0;
      consume("bp");
      check("bp/held_idle", {32'd0, dataOut}, {32'd0, 32'hF000F000});

      run("srl_amt",   32'h80000000, 32'h00000021, OP_SRL,   32'h40000000, 32'h0, 1'b0, 1);
      run("illegal",   32'h12345678, 32'h87654321, OP_BAD,   32'h00000000, 32'h0, 1'b1, 1);
      run("or",        32'h12340000, 32'h00005678, OP_OR,    32'h12345678, 32'h0, 1'b0, 1);
      run("multu_2p32",32'h00010000, 32'h00010000, OP_MULTU, 32'h00000000, 32'h00000001, 1'b0, 33);
      run("sub_neg",   32'd3,        32'd5,        OP_SUB,   32'hFFFFFFFE, 32'h0, 1'b0, 1);
      run("sll_31",    32'h00000001, 32'h0000003F, OP_SLL,   32'h80000000, 32'h0, 1'b0, 1);
      run("multu_small",32'd3,       32'd5,        OP_MULTU, 32'd15,       32'h0, 1'b0, 33);

      // outReady pulsed while idle must not disturb anything.
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      check("idle_ordy/outValid", {63'd0, outValid}, 64'd0);
      check("idle_ordy/inReady", {63'd0, inReady}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the team's 32-bit combinational ALU.
- Keeps the AND/OR/ADD/SUB/SLT function codes unchanged. Adds logical shifts and an unsigned shift-add multiply.
- SLT becomes overflow-correct.
- Sits between the decode stage and writeback. Operands in and results out use valid/ready handshakes.

Parameters:
- WIDTH, 32, operand and result width; must be a power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B.
- Signal  input  6  function code.
- inValid  input  1  operands and Signal are valid this cycle.
- inReady  output  1  block can accept an operation.
- dataOut  output  WIDTH  result, or low half of the product.
- hiOut  output  WIDTH  high half of the product; 0 for all non-multiply ops.
- illegal  output  1  the completed op had an undefined Signal.
- outValid  output  1  result registers are valid.
- outReady  input  1  consumer takes the result.

Behaviour:
- Function codes:
  - AND 100100: A&B.
  - OR 100101: A|B.
  - ADD 100000: A+B, carry discarded.
  - SUB 100010: A-B, modulo 2^WIDTH.
  - SLT 101010: 1 if signed A<B, else 0. Uses (diff_msb XOR overflow), so it is correct on overflow.
  - SLL 000000: A << B[SHW-1:0].
  - SRL 000010: A >> B[SHW-1:0], logical.
  - MULTU 011001: unsigned A*B. {hiOut,dataOut} holds the 2*WIDTH-bit product.
  - Any other code: dataOut=0, hiOut=0, illegal=1.
- Reset: async assert while reset_n=0.
  - State=IDLE, inReady=1, outValid=0, dataOut=0, hiOut=0, illegal=0, counter=0.
  - Release is synchronous to clk.
- States: IDLE, MUL, DONE.
- IDLE: inReady=1. An operation is accepted when inValid&&inReady at a rising edge.
  - Non-MULTU: result registered on the accept edge, go to DONE. outValid is high the next cycle (latency 1).
  - MULTU: on the accept edge, latch multiplicand=A, multiplier=B, product=0, counter=WIDTH, go to MUL. inReady=0.
- MUL: shift-add, one step per cycle.
  - If multiplier[0]=1, add multiplicand into the upper half of product with carry-out.
  - Shift {carry,product} right by 1. Shift multiplier right by 1. Decrement counter.
  - When counter reaches 0 after a step, go to DONE. Latency from accept to outValid = WIDTH+1 cycles.
  - inValid is ignored in this state; no operation is accepted.
- DONE: outValid=1, inReady=0.
  - dataOut, hiOut and illegal are held stable until outValid&&outReady.
  - On that edge go to IDLE. outValid=0 the next cycle.
  - No same-cycle re-accept: at most one op per two cycles for single-cycle ops.
- Outputs are registered and change only on an accept edge, in MUL, or on reset.
- dataA/dataB/Signal may change freely after the accept edge; MULTU uses its latched copies.
- Shift amounts use only the low SHW bits of B; upper bits are ignored.
- reset_n asserted in MUL or DONE aborts the operation and clears the result. No partial result becomes visible.
- outReady high while outValid=0 has no effect.

Test Plan:
- WIDTH=32, ADD: A=0xFFFFFFFF, B=0x00000001, accept -> next cycle outValid=1, dataOut=0x00000000, hiOut=0, illegal=0.
- SLT with overflow: A=0x80000000, B=0x00000001 -> dataOut=1. Then A=0x7FFFFFFF, B=0xFFFFFFFF -> dataOut=0.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF -> outValid rises exactly 33 cycles after accept, hiOut=0xFFFFFFFE, dataOut=0x00000001. inReady=0 throughout.
- Backpressure: AND A=0xF0F0F0F0, B=0xFF00FF00 with outReady=0 for 5 cycles -> dataOut=0xF000F000 held stable, inReady=0, new inValid ignored. outReady=1 -> IDLE next cycle.
- SRL A=0x80000000, B=0x00000021 (amount 1) -> 0x40000000. Signal=6'b111111 -> dataOut=0, illegal=1.
- reset_n pulsed low mid-MULTU (cycle 10) -> immediately outValid=0, dataOut=0, hiOut=0. After release inReady=1 and the next ADD 3+4 returns 7.
